// File: rtl/ysyx_22050078_regfile.sv
// ysyx_22050078_regfile: integer register file with two combinational read
// ports, a never-bypassed debug read port, a committed-write counter and the
// index of the last committed write.
//
// Build option: define YSYX_22050078_REGFILE_BYPASS_EN to forward write-back
// data onto rs1/rs2 when they address the entry being written in the same
// cycle. Without it, such reads return the old stored value.
//
// Entry 0 is hardwired to zero. All state clears asynchronously on rst_n low.

module ysyx_22050078_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_wen,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [63:0]           wr_count,
  output logic [ADDR_WIDTH-1:0] last_wr_addr
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Storage is flip-flops rather than block RAM: every entry must clear
  // asynchronously and reads are zero-latency.
  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [63:0]           wr_count_reg;
  logic [ADDR_WIDTH-1:0] last_wr_addr_reg;
  logic                  write_commit;

  // Writes to x0 are discarded entirely, so they never touch the counters.
  assign write_commit = rd_wen && (rd_addr_in != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      // Each entry loads write-back data when it is the committed target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (write_commit && (rd_addr_in == ADDR_WIDTH'(gi))) begin
          regs_reg[gi] <= rd_data_in;
        end
      end
    end
  endgenerate

  // Commit bookkeeping: count wraps naturally modulo 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_reg     <= '0;
      last_wr_addr_reg <= '0;
    end else if (write_commit) begin
      wr_count_reg     <= wr_count_reg + 64'd1;
      last_wr_addr_reg <= rd_addr_in;
    end
  end

  assign wr_count     = wr_count_reg;
  assign last_wr_addr = last_wr_addr_reg;

  // Read port 1: x0 reads zero; reset forces zero and suppresses forwarding.
  always_comb begin
    rs1_data = '0;
    if (rst_n && (rs1_addr != '0)) begin
      rs1_data = regs_reg[rs1_addr];
`ifdef YSYX_22050078_REGFILE_BYPASS_EN
      if (write_commit && (rs1_addr == rd_addr_in)) begin
        rs1_data = rd_data_in;
      end
`endif
    end
  end

  // Read port 2: same behaviour as port 1, fully independent.
  always_comb begin
    rs2_data = '0;
    if (rst_n && (rs2_addr != '0)) begin
      rs2_data = regs_reg[rs2_addr];
`ifdef YSYX_22050078_REGFILE_BYPASS_EN
      if (write_commit && (rs2_addr == rd_addr_in)) begin
        rs2_data = rd_data_in;
      end
`endif
    end
  end

  // Debug port always shows architectural (stored) state, never forwarded.
  always_comb begin
    dbg_data = '0;
    if (rst_n && (dbg_addr != '0)) begin
      dbg_data = regs_reg[dbg_addr];
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_regfile.sv
// Self-checking bench for ysyx_22050078_regfile. Expected values are pushed
// to a scoreboard queue as stimulus is applied and popped when the DUT output
// is sampled. Honours YSYX_22050078_REGFILE_BYPASS_EN for same-cycle reads.

module tb_ysyx_22050078_regfile;

  localparam int AW = 5;
  localparam int DW = 64;

  localparam int SIG_RS1  = 0;
  localparam int SIG_RS2  = 1;
  localparam int SIG_DBG  = 2;
  localparam int SIG_CNT  = 3;
  localparam int SIG_LAST = 4;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] value;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          rd_wen;
  logic [AW-1:0] rd_addr_in;
  logic [DW-1:0] rd_data_in;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [63:0]   wr_count;
  logic [AW-1:0] last_wr_addr;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  ysyx_22050078_regfile #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_wen      (rd_wen),
    .rd_addr_in  (rd_addr_in),
    .rd_data_in  (rd_data_in),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .wr_count    (wr_count),
    .last_wr_addr(last_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] observe(input int sig);
    case (sig)
      SIG_RS1: return rs1_data;
      SIG_RS2: return rs2_data;
      SIG_DBG: return dbg_data;
      SIG_CNT: return wr_count;
      default: return 64'(last_wr_addr);
    endcase
  endfunction

  function automatic void expect_val(input string name, input int sig, input logic [63:0] value);
    exp_t e;
    e.name  = name;
    e.sig   = sig;
    e.value = value;
    exp_q.push_back(e);
  endfunction

  // One write-back cycle: drive at negedge, commit at posedge, drop enable.
  task automatic do_write(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    rd_wen     = wen;
    rd_addr_in = addr;
    rd_data_in = data;
    @(posedge clk);
    #1;
    rd_wen = 1'b0;
    $display("  write wen=%0d x%0d <= 0x%h", wen, addr, data);
  endtask

  task automatic set_reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] ad);
    rs1_addr = a1;
    rs2_addr = a2;
    dbg_addr = ad;
    #1;
  endtask

  task automatic test_reset;
    exp_t        e;
    logic [63:0] got;
    set_reads(5'd5, 5'd7, 5'd31);
    expect_val("reset_rs1", SIG_RS1, 64'h0);
    expect_val("reset_rs2", SIG_RS2, 64'h0);
    expect_val("reset_dbg", SIG_DBG, 64'h0);
    expect_val("reset_cnt", SIG_CNT, 64'h0);
    expect_val("reset_last", SIG_LAST, 64'h0);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dual_read;
    exp_t        e;
    logic [63:0] got;
    do_write(1'b1, 5'd3, 64'hA);
    do_write(1'b1, 5'd7, 64'hB);
    set_reads(5'd3, 5'd7, 5'd7);
    expect_val("dual_rs1_x3", SIG_RS1, 64'hA);
    expect_val("dual_rs2_x7", SIG_RS2, 64'hB);
    expect_val("dual_dbg_x7", SIG_DBG, 64'hB);
    expect_val("dual_cnt", SIG_CNT, 64'd2);
    expect_val("dual_last", SIG_LAST, 64'd7);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    set_reads(5'd7, 5'd7, 5'd3);
    expect_val("same_idx_rs1", SIG_RS1, 64'hB);
    expect_val("same_idx_rs2", SIG_RS2, 64'hB);
    expect_val("same_idx_dbg", SIG_DBG, 64'hA);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  task automatic test_x0;
    exp_t        e;
    logic [63:0] got;
    do_write(1'b1, 5'd0, 64'hDEAD);
    set_reads(5'd0, 5'd0, 5'd0);
    expect_val("x0_rs1", SIG_RS1, 64'h0);
    expect_val("x0_dbg", SIG_DBG, 64'h0);
    expect_val("x0_cnt", SIG_CNT, 64'd2);
    expect_val("x0_last", SIG_LAST, 64'd7);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  task automatic test_gating;
    exp_t        e;
    logic [63:0] got;
    do_write(1'b0, 5'd4, 64'hFF);
    set_reads(5'd4, 5'd3, 5'd4);
    expect_val("gate_rs1_x4", SIG_RS1, 64'h0);
    expect_val("gate_rs2_x3", SIG_RS2, 64'hA);
    expect_val("gate_dbg_x4", SIG_DBG, 64'h0);
    expect_val("gate_cnt", SIG_CNT, 64'd2);
    expect_val("gate_last", SIG_LAST, 64'd7);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  task automatic test_same_cycle;
    exp_t        e;
    logic [63:0] got;
    logic [63:0] fwd;
`ifdef YSYX_22050078_REGFILE_BYPASS_EN
    fwd = 64'h2;
`else
    fwd = 64'h1;
`endif
    do_write(1'b1, 5'd9, 64'h1);
    @(negedge clk);
    rd_wen     = 1'b1;
    rd_addr_in = 5'd9;
    rd_data_in = 64'h2;
    set_reads(5'd9, 5'd9, 5'd9);
    expect_val("rdw_rs1", SIG_RS1, fwd);
    expect_val("rdw_rs2", SIG_RS2, fwd);
    expect_val("rdw_dbg", SIG_DBG, 64'h1);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    @(posedge clk);
    #1;
    rd_wen = 1'b0;
    #1;
    expect_val("rdw_next_rs1", SIG_RS1, 64'h2);
    expect_val("rdw_next_dbg", SIG_DBG, 64'h2);
    expect_val("rdw_cnt", SIG_CNT, 64'd4);
    expect_val("rdw_last", SIG_LAST, 64'd9);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [63:0] got;
    do_write(1'b1, 5'd12, 64'h111);
    do_write(1'b1, 5'd12, 64'h222);
    set_reads(5'd12, 5'd9, 5'd12);
    expect_val("b2b_rs1_x12", SIG_RS1, 64'h222);
    expect_val("b2b_rs2_x9", SIG_RS2, 64'h2);
    expect_val("b2b_dbg_x12", SIG_DBG, 64'h222);
    expect_val("b2b_cnt", SIG_CNT, 64'd6);
    expect_val("b2b_last", SIG_LAST, 64'd12);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  task automatic test_wrap;
    exp_t        e;
    logic [63:0] got;
    @(negedge clk);
    force dut.wr_count_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.wr_count_reg;
    #1;
    expect_val("wrap_preload", SIG_CNT, 64'hFFFF_FFFF_FFFF_FFFF);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    do_write(1'b1, 5'd1, 64'h55);
    set_reads(5'd1, 5'd0, 5'd1);
    expect_val("wrap_cnt", SIG_CNT, 64'h0);
    expect_val("wrap_last", SIG_LAST, 64'd1);
    expect_val("wrap_rs1_x1", SIG_RS1, 64'h55);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  task automatic test_async_reset;
    exp_t        e;
    logic [63:0] got;
    do_write(1'b1, 5'd5, 64'h1234);
    set_reads(5'd5, 5'd6, 5'd5);
    expect_val("ar_pre_x5", SIG_RS1, 64'h1234);
    expect_val("ar_pre_last", SIG_LAST, 64'd5);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    // Assert reset mid-cycle with a write to x6 pending.
    @(negedge clk);
    rd_wen     = 1'b1;
    rd_addr_in = 5'd6;
    rd_data_in = 64'h77;
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("ar_x5_rs1", SIG_RS1, 64'h0);
    expect_val("ar_x6_rs2_nofwd", SIG_RS2, 64'h0);
    expect_val("ar_x5_dbg", SIG_DBG, 64'h0);
    expect_val("ar_cnt", SIG_CNT, 64'h0);
    expect_val("ar_last", SIG_LAST, 64'h0);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    // A clock edge inside reset must not commit the pending write.
    @(posedge clk);
    #1;
    rd_wen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_reads(5'd6, 5'd6, 5'd6);
    expect_val("ar_lost_x6", SIG_DBG, 64'h0);
    expect_val("ar_lost_cnt", SIG_CNT, 64'h0);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
    do_write(1'b1, 5'd6, 64'h88);
    set_reads(5'd6, 5'd5, 5'd6);
    expect_val("ar_post_x6", SIG_RS1, 64'h88);
    expect_val("ar_post_x5", SIG_RS2, 64'h0);
    expect_val("ar_post_cnt", SIG_CNT, 64'd1);
    expect_val("ar_post_last", SIG_LAST, 64'd6);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = observe(e.sig);
      vectors++;
      if (got !== e.value) begin
        miscompares++;
        $display("FAIL %s: got 0x%h, expected 0x%h", e.name, got, e.value);
      end else $display("  ok %s = 0x%h", e.name, got);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rd_wen      = 1'b0;
    rd_addr_in  = '0;
    rd_data_in  = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    dbg_addr    = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_dual_read();
    test_x0();
    test_gating();
    test_same_cycle();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
